uart_tx_scheduler: RTL and testbench

//   Shares one 8-N-1 UART transmitter between N_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 88 ++++++++
 tb/tb_uart_tx_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one 8-N-1 UART transmitter among N_REQ byte sources,
// with a free-running baud divider and a frame-plus-guard hold-off between grants.
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_GAP     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [8*N_REQ-1:0]         req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_trigger_o,
    output logic                       baud_tick_o,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [4:0] LAST_TICK = 5'(11 + STOP_GAP);

    typedef enum logic [1:0] {IDLE, TRIG, FRAME} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q;
    logic [4:0]      tick_q, tick_d;
    logic [IW-1:0]   ptr_q, ptr_d, gid_q, gid_d, win;
    logic [7:0]      data_q, data_d;

    assign baud_tick_o  = baud_q == CW'(CLKS_PER_BIT - 1);
    assign tx_trigger_o = state_q == TRIG;
    assign busy_o       = state_q != IDLE;
    assign tx_data_o    = data_q;
    assign grant_id_o   = gid_q;

    // Lowest valid index above ptr wins; otherwise wrap to the lowest valid at or below ptr.
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_valid_i[i] && i <= int'(ptr_q)) win = IW'(i);
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_valid_i[i] && i > int'(ptr_q)) win = IW'(i);
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && !rst && |req_valid_i) req_ready_o[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        tick_d  = (state_q != IDLE && baud_tick_o) ? tick_q + 5'd1 : tick_q;
        unique case (state_q)
            IDLE: if (|req_valid_i) begin
                state_d = TRIG;
                tick_d  = '0;
                ptr_d   = win;
                gid_d   = win;
                data_d  = req_data_i[{win, 3'b000} +: 8];
            end
            TRIG:    state_d = (baud_tick_o && tick_q == 5'd1) ? FRAME : TRIG;
            FRAME:   state_d = (baud_tick_o && tick_q == LAST_TICK) ? IDLE : FRAME;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q  <= '0;
            state_q <= IDLE;
            tick_q  <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
        end else begin
            baud_q  <= baud_tick_o ? '0 : baud_q + CW'(1);
            state_q <= state_d;
            tick_q  <= tick_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized traffic against a timeline model of frames (accept cycle,
// trigger end, busy end computed from the baud tick grid), plus directed scenario checks.
module tb_uart_tx_scheduler;
    localparam int N  = 4;
    localparam int C  = 4;
    localparam int G  = 1;
    localparam int FT = 12 + G;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_trigger, baud_tick, busy;
    logic [1:0]       grant_id;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N), .CLKS_PER_BIT(C), .STOP_GAP(G)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_trigger_o(tx_trigger),
        .baud_tick_o(baud_tick), .busy_o(busy), .grant_id_o(grant_id)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int v, input int p);
        for (int d = 1; d <= N; d++)
            if (((v >> ((p + d) % N)) & 1) == 1) return (p + d) % N;
        return -1;
    endfunction

    // Model: t counts cycles since reset (divider value is t mod C); a frame accepted at cycle a
    // owns cycles a+1..be, with the trigger high through te.
    bit        mv = 0;
    int        t, a, te, be, m_ptr, m_gid, k_m, f;
    logic [7:0] m_data;

    always @(negedge clk) begin
        if (mv) begin
            k_m = (!(t > a && t <= be) && !rst) ? rr_pick(int'(req_valid), m_ptr) : -1;
            chk("baud_tick", int'(baud_tick), int'((t % C) == C - 1));
            chk("busy", int'(busy), int'(t > a && t <= be));
            chk("tx_trigger", int'(tx_trigger), int'(t > a && t <= te));
            chk("req_ready", int'(req_ready), k_m >= 0 ? (1 << k_m) : 0);
            chk("tx_data", int'(tx_data), int'(m_data));
            chk("grant_id", int'(grant_id), m_gid);
        end
        if (rst) begin
            mv = 1; t = 0; a = -1; te = -1; be = -1; m_ptr = N - 1; m_gid = 0; m_data = 8'h00;
        end else if (mv) begin
            if (k_m >= 0) begin
                a = t;
                f = t + 1;
                while (f % C != C - 1) f++;
                te = f + C;
                be = f + (FT - 1) * C;
                m_data = 8'(req_data >> (8 * k_m));
                m_gid = k_m;
                m_ptr = k_m;
            end
            t++;
        end
    end

    logic [N-1:0] refill = '0;
    int grants[$];

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready & {N{~rst}};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                grants.push_back(i);
                if (refill[i]) req_data[8*i +: 8] = 8'($urandom);
                else req_valid[i] = 1'b0;
            end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        grants.delete();
    endtask

    task automatic wait_grant(input string name, input int limit);
        int w = 0;
        while (grants.size() == 0 && w < limit) begin step(); w++; end
        if (grants.size() == 0) chk(name, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int bc, n1, gap, ng, prev_busy, w;
        // 1: single request from requester 0
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        do_reset(3);
        step();
        chk("t1_model_trig_end", te, 7);
        chk("t1_model_busy_end", be, 51);
        chk("t1_tx_data", int'(tx_data), 8'hA5);
        chk("t1_grant", int'(grant_id), 0);
        bc = int'(busy);
        repeat (59) begin step(); bc += int'(busy); end
        chk("t1_busy_len", bc, 51);
        chk("t1_accepts", grants.size(), 1);
        // 2: all four valid, continuously refilled
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        refill = '1;
        req_valid = '1;
        do_reset(2);
        w = 0;
        while (grants.size() < 5 && w < 400) begin step(); w++; end
        chk("t2_grant_count", int'(grants.size() >= 5), 1);
        if (grants.size() >= 5) begin
            chk("t2_g0", grants[0], 0);
            chk("t2_g1", grants[1], 1);
            chk("t2_g2", grants[2], 2);
            chk("t2_g3", grants[3], 3);
            chk("t2_g4", grants[4], 0);
        end
        // 3: sole requester 2 held valid
        refill = 4'b0100;
        req_valid = 4'b0100;
        do_reset(2);
        ng = 0; gap = 0; prev_busy = 0;
        repeat (200) begin
            step();
            if (!busy) gap++;
            else begin
                if (!prev_busy && gap > 0 && ng > 0) chk("t3_idle_gap", gap, 1);
                if (!prev_busy) ng++;
                gap = 0;
            end
            prev_busy = int'(busy);
        end
        chk("t3_frames", int'(ng >= 3), 1);
        foreach (grants[i]) chk("t3_owner", grants[i], 2);
        // 4: reset 20 clk into a frame
        refill = '1;
        req_valid = '1;
        do_reset(2);
        step();
        repeat (20) step();
        rst = 1'b1;
        step();
        chk("t4_trig", int'(tx_trigger), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_data", int'(tx_data), 0);
        chk("t4_gid", int'(grant_id), 0);
        chk("t4_ready", int'(req_ready), 0);
        refill = '0;
        req_valid = 4'b1000;
        do_reset(1);
        wait_grant("t4_req3_timeout", 20);
        if (grants.size() > 0) chk("t4_req3_first", grants[0], 3);
        req_valid = '1;
        do_reset(2);
        wait_grant("t4_all_timeout", 20);
        if (grants.size() > 0) chk("t4_all_first", grants[0], 0);
        // 5: requester 1 withdraws while another owns the transmitter
        req_valid = 4'b0001;
        req_data[15:8] = 8'h5A;
        do_reset(2);
        repeat (10) step();
        req_valid[1] = 1'b1;
        repeat (20) step();
        req_valid[1] = 1'b0;
        repeat (60) step();
        n1 = 0;
        foreach (grants[i]) if (grants[i] == 1) n1++;
        chk("t5_req1_grants", n1, 0);
        // 6: random traffic, data stable while valid
        req_valid = '0;
        do_reset(2);
        repeat (1500) begin
            step();
            if ($urandom_range(0, 99) == 0) refill = 4'($urandom);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 39) == 0) req_valid[i] = 1'b0;
        end
        chk("t6_traffic", int'(grants.size() > 10), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
